// File: rtl/uart_tx_sched_if.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_sched_if
//  Purpose  : Two-requester byte request bus for the UART transmit scheduler.
//  Revision : 1.0
// ============================================================================
interface uart_tx_sched_if #(
    parameter int DATA_W = 8
) ();
    logic [1:0]        req_valid;
    logic [DATA_W-1:0] req_data0;
    logic [DATA_W-1:0] req_data1;
    logic [1:0]        req_ready;

    modport master (output req_valid, output req_data0, output req_data1, input  req_ready);
    modport slave  (input  req_valid, input  req_data0, input  req_data1, output req_ready);
endinterface
`default_nettype wire

// File: rtl/uart_tx_sched.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_sched
//  Purpose  : Round-robin two-requester UART transmitter (8N1, or 8E1 when
//             UART_TX_PARITY_EN is defined) with between-frame baud select.
//  Revision : 1.0
// ============================================================================
module uart_tx_sched #(
    parameter int         DATA_W   = 8,
    parameter logic [1:0] RATE_RST = 2'b10
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           i_baud_clk,
    uart_tx_sched_if.slave bus,
    input  logic           i_cfg_we,
    input  logic [1:0]     i_cfg_rate,
    output logic [1:0]     o_baud_rate,
    output logic           o_tx,
    output logic           o_busy,
    output logic           o_grant_id,
    output logic           o_frame_done
);

    localparam int               CNT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(DATA_W - 1);

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_ARM    = 3'd1;
    localparam logic [2:0] c_START  = 3'd2;
    localparam logic [2:0] c_DATA   = 3'd3;
    localparam logic [2:0] c_STOP   = 3'd5;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] c_PARITY = 3'd4;
`endif

    logic [2:0]        r_state;
    logic [2:0]        w_state_nxt;
    logic              r_bclk_q;
    logic              w_tick;
    logic              r_rr;
    logic              r_grant;
    logic [DATA_W-1:0] r_shreg;
    logic [CNT_W-1:0]  r_bitcnt;
    logic              r_tx;
    logic              r_pend;
    logic [1:0]        r_rate_pend;
    logic [1:0]        r_baud_rate;
    logic              w_winner;
    logic [DATA_W-1:0] w_win_data;
    logic              w_open;
    logic              w_accept;
    logic              w_last;
`ifdef UART_TX_PARITY_EN
    logic              r_par;
`endif

    assign w_tick     = i_baud_clk & ~r_bclk_q;
    assign w_last     = (r_bitcnt == c_LAST);
    // With both requesters valid the round-robin pointer decides.
    assign w_winner   = (bus.req_valid == 2'b11) ? r_rr : bus.req_valid[1];
    assign w_win_data = w_winner ? bus.req_data1 : bus.req_data0;
    // A pending rate change owns the IDLE cycle, so no accept happens then.
    assign w_open     = ~rst & (r_state == c_IDLE) & ~r_pend;
    assign w_accept   = w_open & (|bus.req_valid);

    assign o_tx        = r_tx;
    assign o_grant_id  = r_grant;
    assign o_baud_rate = r_baud_rate;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= c_IDLE;
            r_bclk_q <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_bclk_q <= i_baud_clk;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:  if (w_accept) w_state_nxt = c_ARM;
            c_ARM:   if (w_tick)   w_state_nxt = c_START;
            c_START: if (w_tick)   w_state_nxt = c_DATA;
`ifdef UART_TX_PARITY_EN
            c_DATA:   if (w_tick && w_last) w_state_nxt = c_PARITY;
            c_PARITY: if (w_tick)           w_state_nxt = c_STOP;
`else
            c_DATA:   if (w_tick && w_last) w_state_nxt = c_STOP;
`endif
            c_STOP:  if (w_tick)   w_state_nxt = c_IDLE;
            default:               w_state_nxt = c_IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready = 2'b00;
        o_busy        = (r_state != c_IDLE);
        o_frame_done  = ~rst & (r_state == c_STOP) & w_tick;
        if (w_accept) begin
            bus.req_ready = w_winner ? 2'b10 : 2'b01;
        end
    end

    // tx is registered and only moves on bit ticks; each state holds its bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx     <= 1'b1;
            r_shreg  <= '0;
            r_bitcnt <= '0;
            r_rr     <= 1'b0;
            r_grant  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            r_par    <= 1'b0;
`endif
        end else begin
            if (w_accept) begin
                r_shreg <= w_win_data;
                r_rr    <= ~w_winner;
                r_grant <= w_winner;
`ifdef UART_TX_PARITY_EN
                r_par   <= ^w_win_data;
`endif
            end
            if (w_tick) begin
                case (r_state)
                    c_ARM: r_tx <= 1'b0;
                    c_START: begin
                        r_tx     <= r_shreg[0];
                        r_shreg  <= {1'b0, r_shreg[DATA_W-1:1]};
                        r_bitcnt <= '0;
                    end
                    c_DATA: begin
                        if (w_last) begin
`ifdef UART_TX_PARITY_EN
                            r_tx <= r_par;
`else
                            r_tx <= 1'b1;
`endif
                        end else begin
                            r_tx     <= r_shreg[0];
                            r_shreg  <= {1'b0, r_shreg[DATA_W-1:1]};
                            r_bitcnt <= r_bitcnt + CNT_W'(1);
                        end
                    end
`ifdef UART_TX_PARITY_EN
                    c_PARITY: r_tx <= 1'b1;
`endif
                    default: ;
                endcase
            end
        end
    end

    // A write in the apply cycle re-arms pend, so the latest rate always lands.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend      <= 1'b0;
            r_rate_pend <= RATE_RST;
            r_baud_rate <= RATE_RST;
        end else begin
            if ((r_state == c_IDLE) && r_pend) begin
                r_baud_rate <= r_rate_pend;
                r_pend      <= 1'b0;
            end
            if (i_cfg_we) begin
                r_rate_pend <= i_cfg_rate;
                r_pend      <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_tx_sched
//  Purpose  : Directed self-checking bench for uart_tx_sched.
//  Revision : 1.0
// ============================================================================
module tb_uart_tx_sched;

`ifdef UART_TX_PARITY_EN
    localparam int NT = 12;
`else
    localparam int NT = 11;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       baud_clk = 1'b0;
    logic       cfg_we = 1'b0;
    logic [1:0] cfg_rate = 2'b00;
    logic [1:0] baud_rate;
    logic       tx, busy, grant_id, frame_done;

    int n_pass = 0;
    int n_fail = 0;
    int n_total = 0;
    int fd_total = 0;
    logic multi_rdy = 1'b0;

    logic        s_tx, s_busy, s_fd;
    logic [1:0]  s_rdy, s_rate;
    logic [11:0] r_pat;

    uart_tx_sched_if #(.DATA_W(8)) u_if ();

    uart_tx_sched #(.DATA_W(8), .RATE_RST(2'b10)) u_dut (
        .clk          (clk),
        .rst          (rst),
        .i_baud_clk   (baud_clk),
        .bus          (u_if),
        .i_cfg_we     (cfg_we),
        .i_cfg_rate   (cfg_rate),
        .o_baud_rate  (baud_rate),
        .o_tx         (tx),
        .o_busy       (busy),
        .o_grant_id   (grant_id),
        .o_frame_done (frame_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (frame_done) fd_total <= fd_total + 1;
        if (u_if.req_ready == 2'b11) multi_rdy <= 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Two low cycles, then one high cycle of baud_clk; samples just after the tick edge.
    task automatic do_tick();
        repeat (2) @(negedge clk);
        baud_clk = 1'b1;
        #1 s_fd = frame_done;
        @(negedge clk);
        s_tx = tx; s_busy = busy; s_rdy = u_if.req_ready; s_rate = baud_rate;
        baud_clk = 1'b0;
    endtask

    task automatic run_frame(input string tag, input logic [7:0] exp, input bit drop, input int cfg_at);
        logic [11:0] pat;
        int   fdc;
        logic fd_last, busy_pre;
        pat = '0; fdc = 0; fd_last = 1'b0; busy_pre = 1'b0;
        for (int t = 1; t <= NT; t++) begin
            do_tick();
            pat[t-1] = s_tx;
            if (s_fd) fdc++;
            if (t == NT)     fd_last  = s_fd;
            if (t == NT - 1) busy_pre = s_busy;
            if (t == cfg_at) begin
                cfg_we = 1'b1; cfg_rate = 2'b00;
                @(negedge clk);
                cfg_we = 1'b0;
            end
        end
        if (drop) u_if.req_valid = 2'b00;
        r_pat = pat;
        check({tag, ".start"}, 32'(pat[0]), 32'd0);
        check({tag, ".data"}, 32'(pat[8:1]), 32'(exp));
`ifdef UART_TX_PARITY_EN
        check({tag, ".parity"}, 32'(pat[9]), 32'(^exp));
`endif
        check({tag, ".stop"}, 32'(pat[NT-2]), 32'd1);
        check({tag, ".idle"}, 32'(pat[NT-1]), 32'd1);
        check({tag, ".fd_count"}, 32'(fdc), 32'd1);
        check({tag, ".fd_last"}, 32'(fd_last), 32'd1);
        check({tag, ".busy_stop"}, 32'(busy_pre), 32'd1);
        check({tag, ".busy_end"}, 32'(s_busy), 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    int fd_snap;

    initial begin
        u_if.req_valid = 2'b01;
        u_if.req_data0 = 8'hA5;
        u_if.req_data1 = 8'h00;

        // Reset state, with requester 0 already valid.
        repeat (3) @(negedge clk);
        check("rst.tx", 32'(tx), 32'd1);
        check("rst.busy", 32'(busy), 32'd0);
        check("rst.ready", 32'(u_if.req_ready), 32'd0);
        check("rst.grant", 32'(grant_id), 32'd0);
        check("rst.fd", 32'(frame_done), 32'd0);
        check("rst.rate", 32'(baud_rate), 32'h2);

        // Single frame 0xA5 from requester 0.
        rst = 1'b0;
        #1 check("a5.ready", 32'(u_if.req_ready), 32'h1);
        @(negedge clk);
        u_if.req_valid = 2'b00;
        check("a5.busy", 32'(busy), 32'd1);
        check("a5.grant", 32'(grant_id), 32'd0);
        check("a5.tx_arm", 32'(tx), 32'd1);
        run_frame("a5", 8'hA5, 1'b0, 0);
`ifndef UART_TX_PARITY_EN
        check("a5.pattern", 32'(r_pat[9:0]), 32'(10'b1101001010));
`endif

        // Both requesters valid: alternating 0x11 / 0x22.
        do_reset();
        u_if.req_valid = 2'b11;
        u_if.req_data0 = 8'h11;
        u_if.req_data1 = 8'h22;
        #1 check("rr.ready0", 32'(u_if.req_ready), 32'h1);
        @(negedge clk);
        check("rr.grant0", 32'(grant_id), 32'd0);
        run_frame("rr0", 8'h11, 1'b0, 0);
        check("rr.ready1", 32'(s_rdy), 32'h2);
        @(negedge clk);
        check("rr.grant1", 32'(grant_id), 32'd1);
        run_frame("rr1", 8'h22, 1'b0, 0);
        check("rr.ready2", 32'(s_rdy), 32'h1);
        @(negedge clk);
        check("rr.grant2", 32'(grant_id), 32'd0);
        run_frame("rr2", 8'h11, 1'b1, 0);
        check("rr.onehot", 32'(multi_rdy), 32'd0);

        // Rate write mid-frame is deferred to the first IDLE cycle.
        u_if.req_valid = 2'b10;
        u_if.req_data1 = 8'h3C;
        #1 check("cfg.ready", 32'(u_if.req_ready), 32'h2);
        @(negedge clk);
        check("cfg.grant", 32'(grant_id), 32'd1);
        run_frame("cfg0", 8'h3C, 1'b0, 3);
        check("cfg.rate_hold", 32'(s_rate), 32'h2);
        check("cfg.ready_apply", 32'(s_rdy), 32'h0);
        @(negedge clk);
        check("cfg.rate_new", 32'(baud_rate), 32'h0);
        check("cfg.ready_after", 32'(u_if.req_ready), 32'h2);
        @(negedge clk);
        check("cfg.busy2", 32'(busy), 32'd1);
        run_frame("cfg1", 8'h3C, 1'b1, 0);
        check("cfg.rate_kept", 32'(baud_rate), 32'h0);

        // Reset during data bit 3 aborts the frame.
        u_if.req_valid = 2'b01;
        u_if.req_data0 = 8'hF0;
        #1 check("abort.ready", 32'(u_if.req_ready), 32'h1);
        @(negedge clk);
        u_if.req_valid = 2'b00;
        for (int t = 1; t <= 5; t++) do_tick();
        check("abort.tx_bit3", 32'(s_tx), 32'd0);
        fd_snap = fd_total;
        rst = 1'b1;
        @(negedge clk);
        check("abort.tx", 32'(tx), 32'd1);
        check("abort.busy", 32'(busy), 32'd0);
        rst = 1'b0;
        for (int t = 1; t <= 12; t++) do_tick();
        check("abort.no_fd", 32'(fd_total), 32'(fd_snap));
        check("abort.idle_tx", 32'(tx), 32'd1);
        check("abort.rate_rst", 32'(baud_rate), 32'h2);
        u_if.req_valid = 2'b10;
        u_if.req_data1 = 8'h96;
        #1 check("fresh.ready", 32'(u_if.req_ready), 32'h2);
        @(negedge clk);
        u_if.req_valid = 2'b00;
        check("fresh.grant", 32'(grant_id), 32'd1);
        run_frame("fresh", 8'h96, 1'b0, 0);

        // Accept on the same edge as a tick: start bit waits for the next tick.
        @(negedge clk);
        baud_clk = 1'b1;
        u_if.req_valid = 2'b01;
        u_if.req_data0 = 8'hC3;
        @(negedge clk);
        baud_clk = 1'b0;
        u_if.req_valid = 2'b00;
        check("coin.busy", 32'(busy), 32'd1);
        check("coin.tx", 32'(tx), 32'd1);
        run_frame("coin", 8'hC3, 1'b0, 0);

`ifdef UART_TX_PARITY_EN
        u_if.req_valid = 2'b10;
        u_if.req_data1 = 8'h07;
        @(negedge clk);
        u_if.req_valid = 2'b00;
        run_frame("par07", 8'h07, 1'b0, 0);
        check("par07.bit10", 32'(r_pat[9]), 32'd1);
        check("par07.bit11", 32'(r_pat[10]), 32'd1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_tx_sched.md
# uart_tx_sched

Two-requester UART transmit scheduler and baud configurator. Round-robin arbitrates byte requests from two clients and serialises the granted byte onto `tx` as 8N1 (or 8E1 with parity). Bit timing comes from the rising edges of the baud generator's `baud_clk`. Owns the generator's `baud_rate` select and applies rate changes only between frames.

## Interface
- `DATA_W`, default 8: payload bits per frame, sent LSB first.
- `RATE_RST`, default 2'b10: `baud_rate` value after reset.
- `clk` in 1: system clock; one clock for the whole block.
- `rst` in 1: reset, synchronous and active-high.
- `baud_clk` in 1: square wave from the baud generator; each rising edge is one bit tick.
- `req_valid` in 2: per-requester byte valid (bit i = requester i).
- `req_data0` in DATA_W: requester 0 byte.
- `req_data1` in DATA_W: requester 1 byte.
- `req_ready` out 2: per-requester accept; a transfer occurs when valid and ready are both high on a clk edge.
- `cfg_we` in 1: one-cycle write strobe for a new rate.
- `cfg_rate` in 2: new rate code.
- `baud_rate` out 2: rate select driven to the baud generator.
- `tx` out 1: serial line, idle high.
- `busy` out 1: frame in progress (any state other than IDLE).
- `grant_id` out 1: requester of the current or most recent frame.
- `frame_done` out 1: one-cycle pulse on the tick that ends STOP.

## Operation
- Tick detect: `bclk_q` registers `baud_clk`; `tick = baud_clk & ~bclk_q`. `bclk_q` resets to 0.
- States and transitions:
  - IDLE: accept a request per the rules below, then go to ARM.
  - ARM: wait for `tick`, then go to START.
  - START: `tx` = 0; on `tick` go to DATA.
  - DATA: on each `tick`, output the next bit; after DATA_W bits go to STOP (or PARITY if compiled in).
  - STOP: `tx` = 1; on `tick` go to IDLE and pulse `frame_done`.
- `tx` changes only on ticks, plus its reset value.
- Arbitration, in IDLE only:
  - Round-robin pointer `rr` names the preferred requester; resets to 0.
  - If both valid, grant `rr`; if one valid, grant it.
  - On accept: `rr` becomes the other requester, the byte is latched into a shift register, and `grant_id` updates.
- `req_ready[i]` is combinational: high only when in IDLE, no config pending, and requester i is the winner. At most one ready bit is high per cycle.
- Data shift: each DATA `tick` drives `tx` with `shreg[0]` and then shifts right. A bit counter counts 0..DATA_W-1.
- Baud config:
  - `cfg_we` latches `cfg_rate` into `rate_pend` and sets `pend`.
  - In IDLE with `pend` set: `baud_rate <= rate_pend`, `pend` clears, and no request is accepted that cycle.
  - `cfg_we` while busy: the rate is held and applied at the first IDLE cycle after STOP.
  - Repeated writes: the last one wins.
- Reset values: `tx`=1, `busy`=0, `req_ready`=0 during reset, `grant_id`=0, `frame_done`=0, `baud_rate`=RATE_RST. Internally state=IDLE and `pend`=0.
- Reset mid-frame aborts the frame immediately. `tx` returns to 1 on the next edge; no `frame_done` is issued.

## Timing
- Accept at edge N gives ARM from N+1. The start bit begins at the first `tick` after acceptance.
- Frame length is 10 ticks for 8N1 (11 with parity). Bit period is 2·(div+1) clk cycles of the generator.
- Back-to-back frames: the earliest accept is the cycle after the STOP-ending tick. At least one idle-high bit period appears between frames.
- A `tick` in the same cycle as an accept is ignored; ARM needs a fresh tick.
- `cfg_we` and an accept in the same IDLE cycle: the accept wins that cycle, and the config applies at the next IDLE.
- `busy` rises the cycle after accept and falls the cycle after the STOP-ending tick.

## Configuration
- `UART_TX_PARITY_EN` defined:
  - Adds the PARITY state between DATA and STOP.
  - `tx` carries the XOR of the DATA_W payload bits (even parity) for one bit period.
  - Frame is 11 ticks.
- `UART_TX_PARITY_EN` undefined: no PARITY state, and DATA goes directly to STOP.

## Test plan
- Reset, then requester 0 sends 0xA5 (8N1) → `tx` pattern per tick: 0,1,0,1,0,0,1,0,1,1; `frame_done` pulses once; `busy` is high for exactly 10 ticks.
- Both requesters hold valid with 0x11 and 0x22 → frames alternate 0x11, 0x22, 0x11; `grant_id` sequence 0,1,0; one ready bit high at most per cycle.
- `cfg_we` with rate 2'b00 mid-frame → `baud_rate` stays at 2'b10 until the cycle after STOP; that IDLE cycle shows `req_ready`=0; the next frame uses the new rate.
- `rst` asserted during DATA bit 3 → `tx`=1 the next cycle, state IDLE, no `frame_done`; a fresh request then sends correctly.
- Accept coincident with a `tick` → `tx` stays 1 until the following tick, then the start bit.
- With `UART_TX_PARITY_EN`, send 0x07 → parity bit 1 on tick 10, stop on tick 11.
